// File: rtl/iob_cache_line_fill_buffer.sv
// Line fill buffer: gathers the refill beats of one cache line, forwards the critical
// word as soon as its beat lands, and writes the finished line to data memory in one cycle.
module iob_cache_line_fill_buffer #(
  parameter int DATA_W        = 32,
  parameter int BE_DATA_W     = 64,
  parameter int WORD_OFFSET_W = 3,
  parameter int NLINES_W      = 7,
  parameter int LINE2BE_W     = WORD_OFFSET_W - $clog2(BE_DATA_W / DATA_W),
  parameter int LINE_W        = DATA_W * 2**WORD_OFFSET_W
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     fill_start_i,
  input  logic [NLINES_W-1:0]                      fill_index_i,
  input  logic [WORD_OFFSET_W-1:0]                 fill_word_i,
  input  logic                                     replace_i,
  input  logic                                     read_valid_i,
  input  logic [((LINE2BE_W > 0) ? LINE2BE_W : 1)-1:0] read_addr_i,
  input  logic [BE_DATA_W-1:0]                     read_rdata_i,
  output logic                                     busy_o,
  output logic                                     fwd_valid_o,
  output logic [DATA_W-1:0]                        fwd_rdata_o,
  output logic                                     line_wr_en_o,
  output logic [NLINES_W-1:0]                      line_wr_index_o,
  output logic [LINE_W-1:0]                        line_wr_data_o,
  output logic                                     fill_done_o,
  output logic                                     fill_err_o
);

  localparam int AW    = (LINE2BE_W > 0) ? LINE2BE_W : 1;
  localparam int BEATS = 2**LINE2BE_W;
  localparam int SUB_W = WORD_OFFSET_W - LINE2BE_W;

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t                   state_q, state_n;
  logic [BEATS-1:0]         mask_q, mask_n;
  logic [LINE_W-1:0]        line_q, line_n;
  logic [NLINES_W-1:0]      index_q;
  logic [WORD_OFFSET_W-1:0] word_q;
  logic                     fwd_done_q, replace_q;
  logic                     accept, fwd_n, err_n;
  logic [AW-1:0]            beat, crit_beat;
  logic [DATA_W-1:0]        fwd_word;
  int unsigned              sub_sel;

  // With a single beat per line the beat index is always 0.
  assign beat      = (LINE2BE_W == 0) ? '0 : read_addr_i;
  assign crit_beat = AW'(word_q >> SUB_W);
  assign sub_sel   = 32'(word_q) % (2**SUB_W);
  assign fwd_word  = read_rdata_i[sub_sel*DATA_W +: DATA_W];

  always_comb begin
    state_n = state_q;
    mask_n  = mask_q;
    line_n  = line_q;
    accept  = 1'b0;
    fwd_n   = 1'b0;
    err_n   = 1'b0;
    case (state_q)
      IDLE: if (fill_start_i) begin
        state_n = FILL;
        mask_n  = '0;
      end
      FILL: begin
        accept = read_valid_i && replace_i;
        if (accept) begin
          line_n[beat*BE_DATA_W +: BE_DATA_W] = read_rdata_i;
          mask_n[beat] = 1'b1;
          fwd_n = (beat == crit_beat) && !fwd_done_q;
        end
        // Completion is the falling edge of replace; mask check sees any beat merged this cycle.
        if (replace_q && !replace_i) begin
          if (&mask_n) state_n = COMMIT;
          else begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      mask_q          <= '0;
      line_q          <= '0;
      index_q         <= '0;
      word_q          <= '0;
      fwd_done_q      <= 1'b0;
      replace_q       <= 1'b0;
      busy_o          <= 1'b0;
      fwd_valid_o     <= 1'b0;
      fwd_rdata_o     <= '0;
      line_wr_en_o    <= 1'b0;
      line_wr_index_o <= '0;
      line_wr_data_o  <= '0;
      fill_done_o     <= 1'b0;
      fill_err_o      <= 1'b0;
    end else begin
      state_q   <= state_n;
      mask_q    <= mask_n;
      line_q    <= line_n;
      replace_q <= replace_i;
      if (state_q == IDLE && fill_start_i) begin
        index_q    <= fill_index_i;
        word_q     <= fill_word_i;
        fwd_done_q <= 1'b0;
      end
      if (fwd_n) begin
        fwd_done_q  <= 1'b1;
        fwd_rdata_o <= fwd_word;
      end
      fwd_valid_o  <= fwd_n;
      fill_err_o   <= err_n;
      busy_o       <= (state_n != IDLE);
      line_wr_en_o <= (state_n == COMMIT);
      fill_done_o  <= (state_n == COMMIT);
      if (state_n == COMMIT) begin
        line_wr_index_o <= index_q;
        line_wr_data_o  <= line_n;
      end
    end
  end

endmodule

// File: tb/tb_iob_cache_line_fill_buffer.sv
// Scoreboard bench for the line fill buffer: a small line model predicts forwards and commits.
module tb_iob_cache_line_fill_buffer;
  localparam int DATA_W = 32, BE_DATA_W = 64, WORD_OFFSET_W = 3, NLINES_W = 7;
  localparam int LINE_W = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset_i, fill_start_i, replace_i, read_valid_i;
  logic [NLINES_W-1:0]      fill_index_i;
  logic [WORD_OFFSET_W-1:0] fill_word_i;
  logic [1:0]               read_addr_i;
  logic [BE_DATA_W-1:0]     read_rdata_i;
  logic                     busy_o, fwd_valid_o, line_wr_en_o, fill_done_o, fill_err_o;
  logic [DATA_W-1:0]        fwd_rdata_o;
  logic [NLINES_W-1:0]      line_wr_index_o;
  logic [LINE_W-1:0]        line_wr_data_o;

  iob_cache_line_fill_buffer dut (
    .clk_i(clk), .reset_i(reset_i), .fill_start_i(fill_start_i), .fill_index_i(fill_index_i),
    .fill_word_i(fill_word_i), .replace_i(replace_i), .read_valid_i(read_valid_i),
    .read_addr_i(read_addr_i), .read_rdata_i(read_rdata_i), .busy_o(busy_o),
    .fwd_valid_o(fwd_valid_o), .fwd_rdata_o(fwd_rdata_o), .line_wr_en_o(line_wr_en_o),
    .line_wr_index_o(line_wr_index_o), .line_wr_data_o(line_wr_data_o),
    .fill_done_o(fill_done_o), .fill_err_o(fill_err_o));

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {logic [NLINES_W-1:0] idx; logic [LINE_W-1:0] line; bit err;} cmt_t;
  cmt_t        cmt_q[$];
  logic [31:0] fwd_q[$];
  int          fwd_cyc_q[$];

  logic [NLINES_W-1:0]      m_idx;
  logic [WORD_OFFSET_W-1:0] m_word;
  logic [3:0]               m_mask;
  logic [LINE_W-1:0]        m_line = '0;
  bit                       m_fwd;

  cmt_t mc;
  always @(negedge clk) if (!reset_i) begin
    if (fwd_valid_o) begin
      if (fwd_q.size() == 0) chk("fwd_extra", 256'(1), 256'(0));
      else begin
        chk("fwd_data", 256'(fwd_rdata_o), 256'(fwd_q.pop_front()));
        chk("fwd_cyc", 256'(cyc), 256'(fwd_cyc_q.pop_front()));
      end
    end
    if (line_wr_en_o || fill_err_o) begin
      if (cmt_q.size() == 0) chk("cmt_extra", 256'(1), 256'(0));
      else begin
        mc = cmt_q.pop_front();
        chk("cmt_err", 256'(fill_err_o), 256'(mc.err));
        chk("cmt_wr", 256'(line_wr_en_o), 256'(!mc.err));
        chk("cmt_done", 256'(fill_done_o), 256'(!mc.err));
        if (!mc.err) begin
          chk("cmt_idx", 256'(line_wr_index_o), 256'(mc.idx));
          chk("cmt_line", line_wr_data_o, mc.line);
        end
      end
    end
  end

  task automatic start(input logic [NLINES_W-1:0] idx, input logic [WORD_OFFSET_W-1:0] w);
    fill_start_i = 1'b1; fill_index_i = idx; fill_word_i = w; replace_i = 1'b1;
    m_idx = idx; m_word = w; m_mask = '0; m_fwd = 1'b0;
    @(posedge clk); #1;
    fill_start_i = 1'b0;
  endtask

  task automatic beat(input int a, input logic [63:0] d);
    read_valid_i = 1'b1; read_addr_i = a[1:0]; read_rdata_i = d;
    m_line[a*64 +: 64] = d;
    m_mask[a] = 1'b1;
    if (a == int'(m_word >> 1) && !m_fwd) begin
      m_fwd = 1'b1;
      fwd_q.push_back(m_word[0] ? d[63:32] : d[31:0]);
      fwd_cyc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    read_valid_i = 1'b0;
  endtask

  // Called right after the last beat: replace held one more cycle, then dropped.
  task automatic finish(input bit poke);
    bit ok;
    @(posedge clk); #1;
    replace_i = 1'b0;
    ok = &m_mask;
    cmt_q.push_back('{m_idx, m_line, !ok});
    @(negedge clk); chk("early_wr", 256'(line_wr_en_o), 256'(0));
    @(posedge clk); #1;
    if (poke) begin fill_start_i = 1'b1; fill_index_i = 7'h11; end
    @(negedge clk);
    chk("busy_t3", 256'(busy_o), 256'(ok));
    chk("wr_t3", 256'(line_wr_en_o), 256'(ok));
    chk("err_t3", 256'(fill_err_o), 256'(!ok));
    @(posedge clk); #1;
    fill_start_i = 1'b0;
    @(negedge clk);
    chk("busy_t4", 256'(busy_o), 256'(0));
    chk("wr_t4", 256'(line_wr_en_o), 256'(0));
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 256'(busy_o), 256'(0));
    chk({tag, "_fwdv"}, 256'(fwd_valid_o), 256'(0));
    chk({tag, "_fwdd"}, 256'(fwd_rdata_o), 256'(0));
    chk({tag, "_wr"}, 256'(line_wr_en_o), 256'(0));
    chk({tag, "_idx"}, 256'(line_wr_index_o), 256'(0));
    chk({tag, "_data"}, line_wr_data_o, 256'(0));
    chk({tag, "_done"}, 256'(fill_done_o), 256'(0));
    chk({tag, "_err"}, 256'(fill_err_o), 256'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; fill_start_i = 1'b0; replace_i = 1'b0; read_valid_i = 1'b0;
    fill_index_i = '0; fill_word_i = '0; read_addr_i = '0; read_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    reset_i = 1'b0;
    @(posedge clk); #1;

    // Normal fill, critical word 5 (beat 2, upper half)
    start(7'h15, 3'd5);
    for (int k = 0; k < 4; k++) beat(k, 64'h1111_0000_0000_0000 + 64'(k));
    finish(1'b0);

    // Critical word 0
    start(7'h03, 3'd0);
    for (int k = 0; k < 4; k++) beat(k, {$urandom, $urandom});
    finish(1'b0);

    // Slave-error retry: re-burst overwrites, single forward
    start(7'h40, 3'd6);
    for (int k = 0; k < 4; k++) beat(k, 64'hAAAA_0000_0000_0000 + 64'(k));
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) beat(k, 64'hBBBB_0000_0000_0000 + 64'(k));
    finish(1'b0);

    // Truncated fill
    start(7'h22, 3'd1);
    for (int k = 0; k < 3; k++) beat(k, 64'hC0C0_0000_0000_0000 + 64'(k));
    finish(1'b0);

    // fill_start during FILL and COMMIT is ignored
    start(7'h2A, 3'd3);
    beat(0, 64'hD000_0000_0000_0000);
    fill_start_i = 1'b1; fill_index_i = 7'h7F;
    beat(1, 64'hD000_0000_0000_0001);
    fill_start_i = 1'b0;
    beat(3, 64'hD000_0000_0000_0003);
    beat(2, 64'hD000_0000_0000_0002);
    finish(1'b1);

    // Reset mid-fill, then a clean partial fill must error
    start(7'h33, 3'd5);
    beat(0, 64'hE000_0000_0000_0000);
    beat(1, 64'hE000_0000_0000_0001);
    reset_i = 1'b1; replace_i = 1'b0;
    @(posedge clk); #1;
    chk_zero("midrst");
    reset_i = 1'b0; m_line = '0;
    @(posedge clk); #1;
    start(7'h34, 3'd0);
    beat(2, 64'hF000_0000_0000_0002);
    beat(3, 64'hF000_0000_0000_0003);
    finish(1'b0);

    repeat (3) @(posedge clk);
    chk("fwd_left", 256'(fwd_q.size()), 256'(0));
    chk("cmt_left", 256'(cmt_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
